simple_axi_sram_slave: RTL
==========================

SIMPLE_AXI_SRAM_SLAVE -- requirements
Module: simple_axi_sram_slave

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 128, byte capacity of the internal array (power of two, at least 8).
REQ-002 SHALL have parameter WAIT_CYCLES, default 0, idle cycles inserted before each ready/valid assertion.
REQ-003 i_clk  in  1  single clock; all logic on its rising edge.
REQ-004 i_rst  in  1  reset, asynchronous, active-high.
REQ-005 s_axi_awvalid  in  1  write address valid.
REQ-006 s_axi_awready  out  1  write address ready.
REQ-007 s_axi_awaddr  in  32  write byte address.
REQ-008 s_axi_awsize  in  3  write beat size (log2 bytes).
REQ-009 s_axi_wvalid  in  1  write data valid.
REQ-010 s_axi_wready  out  1  write data ready.
REQ-011 s_axi_wdata  in  64  write data, byte k on bits [8k+7:8k].
REQ-012 s_axi_wstrb  in  8  write byte enables.
REQ-013 s_axi_wlast  in  1  last write beat.
REQ-014 s_axi_bvalid  out  1  write response valid.
REQ-015 s_axi_bready  in  1  write response ready.
REQ-016 s_axi_bresp  out  2  write response: 00 OKAY, 10 SLVERR, 11 DECERR.
REQ-017 s_axi_arvalid  in  1  read address valid.
REQ-018 s_axi_arready  out  1  read address ready.
REQ-019 s_axi_araddr  in  32  read byte address.
REQ-020 s_axi_arsize  in  3  read beat size.
REQ-021 s_axi_rvalid  out  1  read data valid.
REQ-022 s_axi_rready  in  1  read data ready.
REQ-023 s_axi_rdata  out  64  read data, aligned 8-byte word.
REQ-024 s_axi_rresp  out  2  read response, same encoding as bresp.
REQ-025 s_axi_rlast  out  1  last read beat, equal to rvalid (single-beat slave).

Function
REQ-026 Write FSM states SHALL be W_ADDR -> W_DATA -> W_RESP -> W_ADDR; read FSM states SHALL be R_ADDR -> R_WAIT -> R_DATA -> R_ADDR; the two FSMs SHALL run independently.
REQ-027 In W_ADDR, awready SHALL pulse high for one cycle, WAIT_CYCLES cycles after awvalid is first seen high; on the handshake the slave SHALL latch awaddr & ~7 and awsize, then enter W_DATA.
REQ-028 In W_DATA, wready SHALL pulse high WAIT_CYCLES cycles after wvalid; on the handshake byte k of wdata SHALL be written to mem[addr+k] for every set wstrb[k] if response is OKAY, then enter W_RESP.
REQ-029 In W_RESP, bvalid SHALL be high with bresp stable until bready is sampled high, then return to W_ADDR; a new AW SHALL NOT be accepted before that.
REQ-030 In R_ADDR, arready SHALL pulse identically to awready; the handshake latches araddr & ~7 and arsize; R_WAIT SHALL last WAIT_CYCLES cycles (zero cycles when WAIT_CYCLES=0).
REQ-031 On entry to R_DATA, rdata SHALL be captured as {mem[a+7],...,mem[a+0]} (0 on error); rvalid=rlast=1 and rdata/rresp stable until rready, then return to R_ADDR.
REQ-032 Response SHALL be SLVERR (10), with no memory write and rdata=0, when size>3 or, for writes, when wlast=0 on the data beat.
REQ-033 A read capture and a write commit in the same cycle to the same word SHALL return the pre-write bytes.
REQ-034 The slave SHALL ignore awsize/arsize for byte selection; byte lanes are chosen by wstrb only.

Reset
REQ-035 While i_rst=1, all FSMs SHALL be in W_ADDR/R_ADDR with awready, wready, bvalid, arready, rvalid, rlast=0, bresp=rresp=00, rdata=0, wait counters=0.
REQ-036 Reset mid-transaction SHALL abandon it without response; memory SHALL be unaffected by reset, and a write is committed only if its W handshake completed before reset.

Configuration
REQ-037 With SIMPLE_AXI_SRAM_DECERR_EN defined, any address >= MEM_BYTES SHALL return DECERR (11), with no write and rdata=0; without it, the address SHALL be taken modulo MEM_BYTES and return OKAY.

Verification
REQ-038 Write 0x...12345678 to 0x04 with wstrb=0xF0, then read 0x00 -> rdata[63:32]=0x12345678, bytes 0-3 unchanged, bresp=rresp=00.
REQ-039 WAIT_CYCLES=3, write to 0x10 -> awready rises 3 cycles after awvalid, wready 3 cycles after wvalid, bvalid held until bready asserted 5 cycles late.
REQ-040 Write with wlast=0 to 0x18 -> bresp=10, mem[0x18..0x1F] unchanged; read with arsize=4 -> rresp=10, rdata=0.
REQ-041 Address 0x80, MEM_BYTES=128: with macro -> bresp/rresp=11, rdata=0; without macro -> acts on word 0x00, OKAY.
REQ-042 Assert i_rst during W_RESP and during R_DATA -> bvalid/rvalid drop immediately; the next write/read completes normally and the committed data persists.

Source files
------------

// File: rtl/simple_axi_sram_slave.sv
// Single-beat AXI SRAM slave with independent write/read FSMs.
// Define SIMPLE_AXI_SRAM_DECERR_EN to answer out-of-range addresses with DECERR.
module simple_axi_sram_slave #(
  parameter int MEM_BYTES   = 128,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awsize,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arsize,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast
);

  localparam int WORDS = MEM_BYTES / 8;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_ADDR,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_ADDR,
    R_WAIT,
    R_DATA
  } r_state_t;

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a >> 3) & 32'(WORDS - 1));
  endfunction

  logic [63:0] mem [WORDS];

  // ---------------- write channel ----------------
  w_state_t    w_state, w_next;
  logic [CW-1:0] w_cnt, w_cnt_n;
  logic [31:0] waddr_q, waddr_n;
  logic [2:0]  wsize_q, wsize_n;
  logic [1:0]  bresp_q, bresp_n;
  logic        awready_c;
  logic        wready_c;
  logic        w_commit;
  logic        w_done;
  logic        w_oor;
  logic [1:0]  w_resp;

  assign w_done = (w_cnt == CW'(WAIT_CYCLES));

`ifdef SIMPLE_AXI_SRAM_DECERR_EN
  assign w_oor = (waddr_q >= 32'(MEM_BYTES));
`else
  assign w_oor = 1'b0;
`endif

  always_comb begin
    w_resp = RESP_OKAY;
    if (w_oor)
      w_resp = RESP_DECERR;
    else if (wsize_q > 3'd3 || !s_axi_wlast)
      w_resp = RESP_SLVERR;
  end

  always_comb begin
    w_next    = w_state;
    w_cnt_n   = w_cnt;
    waddr_n   = waddr_q;
    wsize_n   = wsize_q;
    bresp_n   = bresp_q;
    awready_c = 1'b0;
    wready_c  = 1'b0;
    w_commit  = 1'b0;
    unique case (w_state)
      W_ADDR: begin
        if (s_axi_awvalid) begin
          if (w_done) begin
            awready_c = 1'b1;
            waddr_n   = s_axi_awaddr & ~32'h7;
            wsize_n   = s_axi_awsize;
            w_cnt_n   = '0;
            w_next    = W_DATA;
          end else begin
            w_cnt_n = w_cnt + CW'(1);
          end
        end
      end
      W_DATA: begin
        if (s_axi_wvalid) begin
          if (w_done) begin
            wready_c = 1'b1;
            bresp_n  = w_resp;
            w_commit = (w_resp == RESP_OKAY);
            w_cnt_n  = '0;
            w_next   = W_RESP;
          end else begin
            w_cnt_n = w_cnt + CW'(1);
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready)
          w_next = W_ADDR;
      end
      default: w_next = W_ADDR;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      w_state <= W_ADDR;
      w_cnt   <= '0;
      waddr_q <= '0;
      wsize_q <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      w_cnt   <= w_cnt_n;
      waddr_q <= waddr_n;
      wsize_q <= wsize_n;
      bresp_q <= bresp_n;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge i_clk) begin
    if (w_commit) begin
      for (int k = 0; k < 8; k++) begin
        if (s_axi_wstrb[k])
          mem[word_idx(waddr_q)][8*k +: 8] <= s_axi_wdata[8*k +: 8];
      end
    end
  end

  assign s_axi_awready = awready_c & ~i_rst;
  assign s_axi_wready  = wready_c & ~i_rst;
  assign s_axi_bvalid  = (w_state == W_RESP);
  assign s_axi_bresp   = bresp_q;

  // ---------------- read channel ----------------
  r_state_t    r_state, r_next;
  logic [CW-1:0] r_cnt, r_cnt_n;
  logic [31:0] raddr_q, raddr_n;
  logic [2:0]  rsize_q, rsize_n;
  logic [63:0] rdata_q, rdata_n;
  logic [1:0]  rresp_q, rresp_n;
  logic        arready_c;
  logic        r_done;
  logic        r_capture;
  logic [31:0] rd_addr;
  logic [2:0]  rd_size;
  logic        r_oor;
  logic [1:0]  rd_resp;

  assign r_done = (r_cnt == CW'(WAIT_CYCLES));

  // With no wait states the capture uses the address still on the bus.
  assign rd_addr = (r_state == R_ADDR) ? (s_axi_araddr & ~32'h7) : raddr_q;
  assign rd_size = (r_state == R_ADDR) ? s_axi_arsize : rsize_q;

`ifdef SIMPLE_AXI_SRAM_DECERR_EN
  assign r_oor = (rd_addr >= 32'(MEM_BYTES));
`else
  assign r_oor = 1'b0;
`endif

  always_comb begin
    rd_resp = RESP_OKAY;
    if (r_oor)
      rd_resp = RESP_DECERR;
    else if (rd_size > 3'd3)
      rd_resp = RESP_SLVERR;
  end

  always_comb begin
    r_next    = r_state;
    r_cnt_n   = r_cnt;
    raddr_n   = raddr_q;
    rsize_n   = rsize_q;
    arready_c = 1'b0;
    r_capture = 1'b0;
    unique case (r_state)
      R_ADDR: begin
        if (s_axi_arvalid) begin
          if (r_done) begin
            arready_c = 1'b1;
            raddr_n   = s_axi_araddr & ~32'h7;
            rsize_n   = s_axi_arsize;
            r_cnt_n   = '0;
            if (WAIT_CYCLES == 0) begin
              r_capture = 1'b1;
              r_next    = R_DATA;
            end else begin
              r_next = R_WAIT;
            end
          end else begin
            r_cnt_n = r_cnt + CW'(1);
          end
        end
      end
      R_WAIT: begin
        if (r_cnt == CW'(WAIT_CYCLES - 1)) begin
          r_capture = 1'b1;
          r_cnt_n   = '0;
          r_next    = R_DATA;
        end else begin
          r_cnt_n = r_cnt + CW'(1);
        end
      end
      R_DATA: begin
        if (s_axi_rready)
          r_next = R_ADDR;
      end
      default: r_next = R_ADDR;
    endcase
  end

  always_comb begin
    rdata_n = rdata_q;
    rresp_n = rresp_q;
    if (r_capture) begin
      rresp_n = rd_resp;
      rdata_n = (rd_resp == RESP_OKAY) ? mem[word_idx(rd_addr)] : '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= R_ADDR;
      r_cnt   <= '0;
      raddr_q <= '0;
      rsize_q <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      r_cnt   <= r_cnt_n;
      raddr_q <= raddr_n;
      rsize_q <= rsize_n;
      rdata_q <= rdata_n;
      rresp_q <= rresp_n;
    end
  end

  assign s_axi_arready = arready_c & ~i_rst;
  assign s_axi_rvalid  = (r_state == R_DATA);
  assign s_axi_rlast   = (r_state == R_DATA);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

endmodule
